// File: rtl/test_ram_arbiter_pkg.sv
// Shared widths and FSM encodings for the test_ram arbiter.
package test_ram_arbiter_pkg;
    localparam int TR_ADDR_MSB = 15;
    localparam int TR_DATA_MSB = 7;
    localparam int TRA_CNT_W   = 8;

    typedef enum logic [1:0] {
        TRA_IDLE  = 2'd0,
        TRA_ISSUE = 2'd1,
        TRA_WAIT  = 2'd2,
        TRA_DONE  = 2'd3
    } tra_state_e;
endpackage

// File: rtl/test_ram_arb_pick.sv
// Winner select for the test_ram arbiter. Fixed priority (port 0) by default;
// round-robin tie break when TEST_RAM_ARB_ROUND_ROBIN_EN is defined.
module test_ram_arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic winner
);
`ifdef TEST_RAM_ARB_ROUND_ROBIN_EN
    always_comb begin
        winner = 1'b0;
        if (req0 && req1) winner = ~last_grant;
        else              winner = req1;
    end
`else
    // Only sampled when a request is present, so port 0 always wins when req0 is high.
    always_comb begin
        winner = !req0 && (req1 || last_grant);
    end
`endif
endmodule

// File: rtl/test_ram_arbiter.sv
// Two-port arbiter in front of the single-port test_ram, with a WAIT timeout guard.
// Define TEST_RAM_ARB_ROUND_ROBIN_EN for round-robin tie breaking.
module test_ram_arbiter
    import test_ram_arbiter_pkg::*;
#(
    parameter int ADDR_MSB       = TR_ADDR_MSB,
    parameter int DATA_MSB       = TR_DATA_MSB,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_MSB:0] addr0,
    input  logic [ADDR_MSB:0] addr1,
    input  logic [DATA_MSB:0] wdata0,
    input  logic [DATA_MSB:0] wdata1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_MSB:0] rdata,
    output logic              err,
    output logic              busy,
    output logic              grant,
    output logic              ram_we,
    output logic [ADDR_MSB:0] ram_addr,
    output logic [DATA_MSB:0] ram_data_in,
    input  logic [DATA_MSB:0] ram_data_out,
    input  logic              ram_data_ready
);
    localparam logic [TRA_CNT_W-1:0] TMO     = TRA_CNT_W'(TIMEOUT_CYCLES);
    localparam logic [TRA_CNT_W-1:0] CNT_MAX = '1;

    tra_state_e           state_q, state_d;
    logic [TRA_CNT_W-1:0] cnt_q;
    logic                 we_l;
    logic                 winner;
    logic                 last_grant;
    logic                 wait_done;

    assign wait_done = ram_data_ready || (cnt_q == TMO);

`ifdef TEST_RAM_ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                      last_grant <= 1'b1;
        else if (state_q == TRA_DONE) last_grant <= grant;
    end
`else
    assign last_grant = 1'b1;
`endif

    test_ram_arb_pick u_pick (
        .req0       (req0),
        .req1       (req1),
        .last_grant (last_grant),
        .winner     (winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= TRA_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            TRA_IDLE:  if (req0 || req1) state_d = TRA_ISSUE;
            TRA_ISSUE: state_d = TRA_WAIT;
            TRA_WAIT:  if (wait_done) state_d = TRA_DONE;
            TRA_DONE:  state_d = TRA_IDLE;
            default:   state_d = TRA_IDLE;
        endcase
    end

    // Outputs are loaded one state early so each is registered yet lines up with its state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack0        <= 1'b0;
            ack1        <= 1'b0;
            rdata       <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
            grant       <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            we_l        <= 1'b0;
            cnt_q       <= '0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            busy <= (state_d != TRA_IDLE);
            case (state_q)
                TRA_IDLE: if (req0 || req1) begin
                    grant       <= winner;
                    we_l        <= winner ? we1 : we0;
                    ram_we      <= winner ? we1 : we0;
                    ram_addr    <= winner ? addr1 : addr0;
                    ram_data_in <= winner ? wdata1 : wdata0;
                end
                TRA_ISSUE: begin
                    ram_we <= 1'b0;
                    cnt_q  <= '0;
                end
                TRA_WAIT: begin
                    if (ram_data_ready) begin
                        if (!we_l) rdata <= ram_data_out;
                        err <= 1'b0;
                    end else if (cnt_q == TMO) begin
                        err <= 1'b1;
                    end else if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    if (wait_done) begin
                        ack0 <= ~grant;
                        ack1 <= grant;
                    end
                end
                TRA_DONE: err <= 1'b0;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_test_ram_arbiter.sv
// Directed bench for test_ram_arbiter with a behavioural test_ram model.
module tb_test_ram_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
    logic [15:0] addr0 = '0, addr1 = '0;
    logic [7:0]  wdata0 = '0, wdata1 = '0;
    logic        ack0, ack1, err, busy, grant, ram_we;
    logic [7:0]  rdata, ram_data_in, ram_data_out;
    logic [15:0] ram_addr;
    logic        ram_data_ready;
    logic        rdy_en = 1'b1;
    logic [7:0]  mem [0:65535];

    int n_chk = 0, n_pass = 0;
    int we_cnt, wrong_ack;
    logic [15:0] we_addr;
    logic [7:0]  we_data;

    test_ram_arbiter #(.ADDR_MSB(15), .DATA_MSB(7), .TIMEOUT_CYCLES(15)) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata(rdata), .err(err), .busy(busy),
        .grant(grant), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out),
        .ram_data_ready(ram_data_ready)
    );

    always #5 clk = ~clk;

    assign ram_data_out   = mem[ram_addr];
    assign ram_data_ready = rdy_en;
    always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_data_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request, wait for its ack, record RAM-side write activity, drop req.
    task automatic access(input logic p, input logic w, input logic [15:0] a,
                          input logic [7:0] d, output int cyc, output logic e,
                          output logic [7:0] rd);
        logic got;
        got = 1'b0; cyc = 0; we_cnt = 0; wrong_ack = 0;
        if (p) begin req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d; end
        else   begin req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d; end
        while (!got && cyc < 40) begin
            tick();
            cyc++;
            if (ram_we) begin we_cnt++; we_addr = ram_addr; we_data = ram_data_in; end
            if (p ? ack0 : ack1) wrong_ack++;
            if (p ? ack1 : ack0) got = 1'b1;
        end
        if (!got) chk("ack_never_seen", 32'd0, 32'd1);
        e = err; rd = rdata;
        req0 = 1'b0; req1 = 1'b0;
    endtask

    initial begin
        int cyc, cnt;
        logic e;
        logic [7:0] rd, exp_last;
        logic [3:0] exp_ports;
        logic port;

        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0010] = 8'hA5;
        mem[16'h0000] = 8'h11; mem[16'h0001] = 8'h22;
        mem[16'h0002] = 8'h33; mem[16'h0003] = 8'h44;

        tick(); tick();
        rst = 1'b0;
        tick();
        chk("reset_outs", {ack0, ack1, err, busy, grant, ram_we}, 32'd0);
        chk("reset_data", {ram_addr, ram_data_in, rdata}, 32'd0);

        access(1'b0, 1'b0, 16'h0010, 8'h00, cyc, e, rd);
        chk("rd_latency", cyc, 3);
        chk("rd_no_we", we_cnt, 0);
        chk("rd_data", rd, 8'hA5);
        chk("rd_err", e, 0);
        chk("rd_wrong_ack", wrong_ack, 0);
        tick();
        chk("rd_idle_after", {busy, ack0}, 0);

        access(1'b1, 1'b1, 16'h0200, 8'h3C, cyc, e, rd);
        chk("wr_we_pulses", we_cnt, 1);
        chk("wr_addr", we_addr, 16'h0200);
        chk("wr_data", we_data, 8'h3C);
        chk("wr_latency", cyc, 3);
        chk("wr_rdata_held", rd, 8'hA5);
        chk("wr_wrong_ack", wrong_ack, 0);
        tick();
        access(1'b1, 1'b0, 16'h0200, 8'h00, cyc, e, rd);
        chk("rdback_data", rd, 8'h3C);
        chk("rdback_grant", grant, 1);
        tick();

`ifdef TEST_RAM_ARB_ROUND_ROBIN_EN
        exp_ports = 4'b1010;
`else
        exp_ports = 4'b0000;
`endif
        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
        req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0200;
        for (int k = 0; k < 4; k++) begin
            cnt = 0;
            do begin tick(); cnt++; end while (!(ack0 || ack1) && cnt < 20);
            if (!(ack0 || ack1)) chk("cont_ack_never_seen", 32'd0, 32'd1);
            port = ack1;
            chk("cont_port", port, exp_ports[k]);
            chk("cont_data", rdata, port ? 8'h3C : 8'hA5);
            if (k == 3) begin req0 = 1'b0; req1 = 1'b0; end
        end
        exp_last = exp_ports[3] ? 8'h3C : 8'hA5;
        tick();

        rdy_en = 1'b0;
        access(1'b0, 1'b0, 16'h0010, 8'h00, cyc, e, rd);
        chk("tmo_latency", cyc, 18);
        chk("tmo_err", e, 1);
        chk("tmo_rdata_held", rd, exp_last);
        tick();
        chk("tmo_busy_after", {busy, ack0}, 0);

        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
        tick(); tick(); tick();
        chk("rst_wait_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("rst_wait_outs", {ack0, ack1, err, busy, grant, ram_we}, 0);
        chk("rst_wait_data", {ram_addr, ram_data_in, rdata}, 0);
        req0 = 1'b0;
        cnt = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (ack0 || ack1) cnt++; end
        chk("rst_no_ack", cnt, 0);
        rst = 1'b0; rdy_en = 1'b1;
        tick();
        access(1'b0, 1'b0, 16'h0010, 8'h00, cyc, e, rd);
        chk("post_rst_latency", cyc, 3);
        chk("post_rst_data", rd, 8'hA5);
        tick();

        req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0300; wdata1 = 8'h5A;
        tick();
        chk("issue_we_high", ram_we, 1);
        rst = 1'b1;
        #1;
        chk("issue_rst_we_drop", ram_we, 0);
        req1 = 1'b0; we1 = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        chk("issue_rst_no_write", mem[16'h0300], 8'h00);

        req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            cnt = 0;
            do begin tick(); cnt++; end while (!ack0 && cnt < 20);
            chk("b2b_gap", cnt, (i == 0) ? 3 : 4);
            chk("b2b_data", rdata, 8'h11 * (i + 1));
            if (i == 3) req0 = 1'b0;
            else        addr0 = 16'(i + 1);
        end
        tick();
        chk("b2b_idle", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
